vga_timing_gen: RTL and testbench

//  Raster timing generator for the DE0-Nano VGA path; sits directly upstream of demo2_text.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/vga_sync_delay.sv | 41 ++++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA path (800x600@72Hz, 50 MHz pixel clock).
// The coordinate type and default constants are also used by the downstream text renderer.
package vga_timing_pkg;

  // Raster coordinate, wide enough for totals up to 2048
  localparam int COORD_W         = 11;
  localparam int COORD_MAX_TOTAL = 2048;
  typedef logic [COORD_W-1:0] coord_t;

  // Horizontal defaults, in pixels
  localparam int DEF_H_VIS  = 800;
  localparam int DEF_H_FP   = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP   = 64;

  // Vertical defaults, in lines
  localparam int DEF_V_VIS  = 600;
  localparam int DEF_V_FP   = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP   = 23;

  // Derived default totals and half-open sync windows [START, END)
  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam coord_t DEF_HS_START = coord_t'(DEF_H_VIS + DEF_H_FP);
  localparam coord_t DEF_HS_END   = coord_t'(DEF_H_VIS + DEF_H_FP + DEF_H_SYNC);
  localparam coord_t DEF_VS_START = coord_t'(DEF_V_VIS + DEF_V_FP);
  localparam coord_t DEF_VS_END   = coord_t'(DEF_V_VIS + DEF_V_FP + DEF_V_SYNC);

  // Sync/blank bundle carried through the alignment delay line
  typedef struct packed {
    logic blank;
    logic vsync;
    logic hsync;
  } sync_bus_t;

  // Advance a raster coordinate, wrapping to 0 after the last position
  function automatic coord_t next_coord(input coord_t c, input coord_t last);
    return (c == last) ? '0 : c + coord_t'(1);
  endfunction

  // Unsigned half-open window test: lo <= c < hi
  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Aligns the sync/blank bundle with the renderer's pixel latency.
// DEPTH-stage shift register that advances on ce and flushes to RST_VAL on reset;
// DEPTH = 0 is a straight wire.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int        DEPTH   = 2,
  parameter sync_bus_t RST_VAL = sync_bus_t'(3'b100)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ce,
  input  sync_bus_t din,
  output sync_bus_t dout
);

  if (DEPTH < 0 || DEPTH > 15) begin : g_bad_depth
    $error("vga_sync_delay: DEPTH must be within 0..15");
  end

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, ce};
    assign dout        = din;
  end else begin : g_pipe
    sync_bus_t stage_p [DEPTH];

    // Shift one stage per enabled pixel; reset fills every stage with the inactive value
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
      end else if (ce) begin
        stage_p[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator feeding the text renderer: pixel coordinates, HSYNC/VSYNC/BLANK,
// a frame-start pulse, and copies of sync/blank delayed to match the renderer's latency.
// Sync and blank are decoded from the next counter values so they line up with PIXEL_H/V.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VIS      = DEF_H_VIS,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_VIS      = DEF_V_VIS,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   SYNC_DELAY = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   PIX_CE,
  output coord_t PIXEL_H,
  output coord_t PIXEL_V,
  output logic   HSYNC,
  output logic   VSYNC,
  output logic   BLANK,
  output logic   FRAME_START,
  output logic   HSYNC_D,
  output logic   VSYNC_D,
  output logic   BLANK_D
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 2048");
  end

  // 11-bit timing landmarks; all comparisons against them are unsigned
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

  // Registered raster state (stage 0)
  coord_t h_p0;
  coord_t v_p0;
  logic   hsync_p0;
  logic   vsync_p0;
  logic   blank_p0;
  logic   frame_start_p0;

  // Next-state values and decodes
  coord_t h_nxt;
  coord_t v_nxt;
  logic   h_wrap;
  logic   v_wrap;
  logic   hsync_nxt;
  logic   vsync_nxt;
  logic   blank_nxt;

  // Compute the next raster position and decode sync/blank for it
  always_comb begin
    h_wrap    = (h_p0 == H_LAST);
    v_wrap    = h_wrap && (v_p0 == V_LAST);
    h_nxt     = next_coord(h_p0, H_LAST);
    v_nxt     = v_p0;
    if (h_wrap) v_nxt = next_coord(v_p0, V_LAST);
    hsync_nxt = in_window(h_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
    vsync_nxt = in_window(v_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
    blank_nxt = (h_nxt >= H_VIS_C) || (v_nxt >= V_VIS_C);
  end

  // --- stage 0: raster counters and registered sync/blank ---
  // Advance on enabled pixels; a disabled pixel holds state and suppresses the frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      h_p0           <= '0;
      v_p0           <= '0;
      hsync_p0       <= ~HS_POL;
      vsync_p0       <= ~VS_POL;
      blank_p0       <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else if (PIX_CE) begin
      h_p0           <= h_nxt;
      v_p0           <= v_nxt;
      hsync_p0       <= hsync_nxt;
      vsync_p0       <= vsync_nxt;
      blank_p0       <= blank_nxt;
      frame_start_p0 <= v_wrap;
    end else begin
      frame_start_p0 <= 1'b0;
    end
  end

  assign PIXEL_H     = h_p0;
  assign PIXEL_V     = v_p0;
  assign HSYNC       = hsync_p0;
  assign VSYNC       = vsync_p0;
  assign BLANK       = blank_p0;
  assign FRAME_START = frame_start_p0;

  // --- stage 1..SYNC_DELAY: latency-matched copies of sync/blank ---
  sync_bus_t sync_p0;
  sync_bus_t sync_dly;

  assign sync_p0 = '{blank: blank_p0, vsync: vsync_p0, hsync: hsync_p0};

  vga_sync_delay #(
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ('{blank: 1'b1, vsync: ~VS_POL, hsync: ~HS_POL})
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (PIX_CE),
    .din   (sync_p0),
    .dout  (sync_dly)
  );

  assign HSYNC_D = sync_dly.hsync;
  assign VSYNC_D = sync_dly.vsync;
  assign BLANK_D = sync_dly.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// dut: default horizontal timing, shortened vertical (6/2/2/2 -> 12 lines, VSYNC on lines 8..9),
//      SYNC_DELAY=2, so a full frame is 12480 enabled cycles.
// dut0: tiny 16x8 raster, active-low syncs, SYNC_DELAY=0 bypass.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic   clk;
  logic   reset;
  logic   pix_ce;

  coord_t h, v;
  logic   hs, vs, bl, fs, hs_d, vs_d, bl_d;
  coord_t h0, v0;
  logic   hs0, vs0, bl0, fs0, hs0_d, vs0_d, bl0_d;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset), .PIX_CE(pix_ce),
    .PIXEL_H(h), .PIXEL_V(v), .HSYNC(hs), .VSYNC(vs), .BLANK(bl), .FRAME_START(fs),
    .HSYNC_D(hs_d), .VSYNC_D(vs_d), .BLANK_D(bl_d)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .PIX_CE(pix_ce),
    .PIXEL_H(h0), .PIXEL_V(v0), .HSYNC(hs0), .VSYNC(vs0), .BLANK(bl0), .FRAME_START(fs0),
    .HSYNC_D(hs0_d), .VSYNC_D(vs0_d), .BLANK_D(bl0_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given enable; outputs are sampled 1 ns after the edge
  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic run_to(input int th, input int tv);
    int n;
    n = 0;
    while (!(h == coord_t'(th) && v == coord_t'(tv)) && n < 13000) begin
      tick(1'b1);
      n++;
    end
    checks++;
    if (!(h == coord_t'(th) && v == coord_t'(tv))) begin
      errors++;
      $display("FAIL run_to_timeout got h=%0d v=%0d want h=%0d v=%0d", h, v, th, tv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1);
    checks++; if (h !== 11'd0)  begin errors++; $display("FAIL reset_h got %0d want 0", h); end
    checks++; if (v !== 11'd0)  begin errors++; $display("FAIL reset_v got %0d want 0", v); end
    checks++; if (hs !== 1'b0)  begin errors++; $display("FAIL reset_hsync got %b want 0", hs); end
    checks++; if (vs !== 1'b0)  begin errors++; $display("FAIL reset_vsync got %b want 0", vs); end
    checks++; if (bl !== 1'b0)  begin errors++; $display("FAIL reset_blank got %b want 0", bl); end
    checks++; if (bl_d !== 1'b1) begin errors++; $display("FAIL reset_blank_d got %b want 1", bl_d); end
    checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL reset_hsync_d got %b want 0", hs_d); end
    checks++; if (fs !== 1'b0)  begin errors++; $display("FAIL reset_frame_start got %b want 0", fs); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL reset_hsync_lowpol got %b want 1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL reset_vsync_lowpol got %b want 1", vs0); end
    reset = 1'b0;
    tick(1'b1);
    checks++; if (h !== 11'd1)  begin errors++; $display("FAIL release_h got %0d want 1", h); end
    checks++; if (v !== 11'd0)  begin errors++; $display("FAIL release_v got %0d want 0", v); end
    checks++; if (fs !== 1'b0)  begin errors++; $display("FAIL release_frame_start got %b want 0", fs); end
  endtask

  task automatic test_line();
    run_n(798);
    checks++; if (h !== 11'd799) begin errors++; $display("FAIL line_h799 got %0d want 799", h); end
    checks++; if (bl !== 1'b0)   begin errors++; $display("FAIL line_blank799 got %b want 0", bl); end
    run_n(1);
    checks++; if (bl !== 1'b1)   begin errors++; $display("FAIL line_blank800 got %b want 1", bl); end
    run_n(55);
    checks++; if (hs !== 1'b0)   begin errors++; $display("FAIL line_hsync855 got %b want 0", hs); end
    run_n(1);
    checks++; if (h !== 11'd856) begin errors++; $display("FAIL line_h856 got %0d want 856", h); end
    checks++; if (hs !== 1'b1)   begin errors++; $display("FAIL line_hsync856 got %b want 1", hs); end
    run_n(119);
    checks++; if (hs !== 1'b1)   begin errors++; $display("FAIL line_hsync975 got %b want 1", hs); end
    run_n(1);
    checks++; if (hs !== 1'b0)   begin errors++; $display("FAIL line_hsync976 got %b want 0", hs); end
    run_n(63);
    checks++; if (h !== 11'd1039) begin errors++; $display("FAIL line_h1039 got %0d want 1039", h); end
    checks++; if (v !== 11'd0)    begin errors++; $display("FAIL line_v_before_wrap got %0d want 0", v); end
    run_n(1);
    checks++; if (h !== 11'd0)   begin errors++; $display("FAIL line_wrap_h got %0d want 0", h); end
    checks++; if (v !== 11'd1)   begin errors++; $display("FAIL line_wrap_v got %0d want 1", v); end
    checks++; if (fs !== 1'b0)   begin errors++; $display("FAIL line_wrap_fs got %b want 0", fs); end
  endtask

  // Starts at (0,1), 1040 enabled cycles after reset release; the frame wraps 11440 cycles later
  task automatic test_frame();
    int   vs_cnt, vs_bad, fs_cnt, fs_at, nonblank, vmin, vmax, d_bad;
    logic vs_prev, hs_h1, hs_h2, bl_h1, bl_h2;
    vs_cnt = 0; vs_bad = 0; fs_cnt = 0; fs_at = -1; nonblank = 0;
    vmin = 4095; vmax = -1; d_bad = 0;
    vs_prev = vs; hs_h1 = hs; bl_h1 = bl; hs_h2 = 1'b0; bl_h2 = 1'b0;
    for (int n = 1; n <= 11440; n++) begin
      tick(1'b1);
      if (vs) begin
        vs_cnt++;
        if (int'(v) < vmin) vmin = int'(v);
        if (int'(v) > vmax) vmax = int'(v);
      end
      if (vs !== vs_prev && h !== 11'd0) vs_bad++;
      if (!bl) nonblank++;
      if (fs) begin fs_cnt++; fs_at = n; end
      if (n >= 2 && (hs_d !== hs_h2 || bl_d !== bl_h2)) d_bad++;
      vs_prev = vs;
      hs_h2 = hs_h1; hs_h1 = hs;
      bl_h2 = bl_h1; bl_h1 = bl;
    end
    checks++; if (fs_cnt !== 1)      begin errors++; $display("FAIL frame_fs_count got %0d want 1", fs_cnt); end
    checks++; if (fs_at + 1040 !== 12480) begin errors++; $display("FAIL frame_fs_cycle got %0d want 12480", fs_at + 1040); end
    checks++; if (h !== 11'd0 || v !== 11'd0) begin errors++; $display("FAIL frame_fs_pos got h=%0d v=%0d want h=0 v=0", h, v); end
    checks++; if (fs !== 1'b1)       begin errors++; $display("FAIL frame_fs_now got %b want 1", fs); end
    checks++; if (vs_cnt !== 2080)   begin errors++; $display("FAIL frame_vsync_cycles got %0d want 2080", vs_cnt); end
    checks++; if (vmin !== 8)        begin errors++; $display("FAIL frame_vsync_first got %0d want 8", vmin); end
    checks++; if (vmax !== 9)        begin errors++; $display("FAIL frame_vsync_last got %0d want 9", vmax); end
    checks++; if (vs_bad !== 0)      begin errors++; $display("FAIL frame_vsync_midline got %0d want 0", vs_bad); end
    checks++; if (nonblank !== 4000) begin errors++; $display("FAIL frame_visible got %0d want 4000", nonblank); end
    checks++; if (d_bad !== 0)       begin errors++; $display("FAIL frame_delay2 got %0d want 0", d_bad); end
  endtask

  task automatic test_ce_toggle();
    tick(1'b0);
    checks++; if (h !== 11'd0)  begin errors++; $display("FAIL ce_hold_h got %0d want 0", h); end
    checks++; if (fs !== 1'b0)  begin errors++; $display("FAIL ce_fs_forced got %b want 0", fs); end
    run_n(854);
    checks++; if (h !== 11'd854) begin errors++; $display("FAIL ce_h854 got %0d want 854", h); end
    tick(1'b1);
    tick(1'b0);
    checks++; if (h !== 11'd855) begin errors++; $display("FAIL ce_hold855 got %0d want 855", h); end
    tick(1'b1);
    checks++; if (hs !== 1'b1 || hs_d !== 1'b0) begin errors++; $display("FAIL ce_hs_rise got hs=%b hs_d=%b want hs=1 hs_d=0", hs, hs_d); end
    tick(1'b0);
    checks++; if (h !== 11'd856 || hs_d !== 1'b0) begin errors++; $display("FAIL ce_hold856 got h=%0d hs_d=%b want h=856 hs_d=0", h, hs_d); end
    tick(1'b1);
    checks++; if (h !== 11'd857 || hs_d !== 1'b0) begin errors++; $display("FAIL ce_d_one got h=%0d hs_d=%b want h=857 hs_d=0", h, hs_d); end
    tick(1'b0);
    checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL ce_d_hold got %b want 0", hs_d); end
    tick(1'b1);
    checks++; if (h !== 11'd858 || hs_d !== 1'b1) begin errors++; $display("FAIL ce_d_two got h=%0d hs_d=%b want h=858 hs_d=1", h, hs_d); end
    run_to(1038, 11);
    tick(1'b1);
    checks++; if (h !== 11'd1039 || fs !== 1'b0) begin errors++; $display("FAIL ce_pre_wrap got h=%0d fs=%b want h=1039 fs=0", h, fs); end
    tick(1'b0);
    checks++; if (h !== 11'd1039 || fs !== 1'b0) begin errors++; $display("FAIL ce_pre_wrap_hold got h=%0d fs=%b want h=1039 fs=0", h, fs); end
    tick(1'b1);
    checks++; if (h !== 11'd0 || v !== 11'd0 || fs !== 1'b1) begin errors++; $display("FAIL ce_wrap got h=%0d v=%0d fs=%b want 0 0 1", h, v, fs); end
    tick(1'b0);
    checks++; if (h !== 11'd0 || fs !== 1'b0) begin errors++; $display("FAIL ce_wrap_hold got h=%0d fs=%b want h=0 fs=0", h, fs); end
    tick(1'b1);
    checks++; if (h !== 11'd1 || fs !== 1'b0) begin errors++; $display("FAIL ce_post_wrap got h=%0d fs=%b want h=1 fs=0", h, fs); end
  endtask

  task automatic test_reset_mid();
    run_to(900, 8);
    checks++; if (hs !== 1'b1 || vs !== 1'b1 || hs_d !== 1'b1) begin errors++; $display("FAIL mid_pre got hs=%b vs=%b hs_d=%b want 1 1 1", hs, vs, hs_d); end
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    checks++; if (h !== 11'd0 || v !== 11'd0) begin errors++; $display("FAIL mid_pos got h=%0d v=%0d want 0 0", h, v); end
    checks++; if (hs !== 1'b0 || vs !== 1'b0) begin errors++; $display("FAIL mid_sync got hs=%b vs=%b want 0 0", hs, vs); end
    checks++; if (hs_d !== 1'b0 || vs_d !== 1'b0 || bl_d !== 1'b1) begin errors++; $display("FAIL mid_flush got hs_d=%b vs_d=%b bl_d=%b want 0 0 1", hs_d, vs_d, bl_d); end
    checks++; if (bl !== 1'b0 || fs !== 1'b0) begin errors++; $display("FAIL mid_blank_fs got bl=%b fs=%b want 0 0", bl, fs); end
    tick(1'b0);
    checks++; if (h !== 11'd0 || bl_d !== 1'b1) begin errors++; $display("FAIL mid_hold got h=%0d bl_d=%b want 0 1", h, bl_d); end
    tick(1'b1);
    checks++; if (h !== 11'd1 || bl_d !== 1'b1) begin errors++; $display("FAIL mid_en1 got h=%0d bl_d=%b want 1 1", h, bl_d); end
    tick(1'b1);
    checks++; if (h !== 11'd2 || bl_d !== 1'b0) begin errors++; $display("FAIL mid_en2 got h=%0d bl_d=%b want 2 0", h, bl_d); end
  endtask

  // Tiny raster: H_TOTAL=16 (HSYNC low on 10..12), V_TOTAL=8 (VSYNC low on lines 5..6), frame=128
  task automatic test_zero_delay();
    int  bypass_bad, sync_bad, fs_cnt, fs_first;
    logic exp_hs, exp_vs, exp_bl;
    bypass_bad = 0; sync_bad = 0; fs_cnt = 0; fs_first = -1;
    reset = 1'b1;
    tick(1'b1);
    tick(1'b1);
    checks++; if (bl0_d !== bl0 || hs0_d !== 1'b1) begin errors++; $display("FAIL zd_reset got bl0_d=%b hs0_d=%b want %b 1", bl0_d, hs0_d, bl0); end
    reset = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick(1'b1);
      exp_hs = !(h0 >= 11'd10 && h0 < 11'd13);
      exp_vs = !(v0 >= 11'd5 && v0 < 11'd7);
      exp_bl = (h0 >= 11'd8) || (v0 >= 11'd4);
      if (hs0_d !== hs0 || vs0_d !== vs0 || bl0_d !== bl0) bypass_bad++;
      if (hs0 !== exp_hs || vs0 !== exp_vs || bl0 !== exp_bl) sync_bad++;
      if (fs0) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = n;
      end
    end
    checks++; if (bypass_bad !== 0) begin errors++; $display("FAIL zd_bypass got %0d want 0", bypass_bad); end
    checks++; if (sync_bad !== 0)   begin errors++; $display("FAIL zd_decode got %0d want 0", sync_bad); end
    checks++; if (fs_cnt !== 2)     begin errors++; $display("FAIL zd_fs_count got %0d want 2", fs_cnt); end
    checks++; if (fs_first !== 128) begin errors++; $display("FAIL zd_fs_first got %0d want 128", fs_first); end
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b1;
    test_reset();
    test_line();
    test_frame();
    test_ce_toggle();
    test_reset_mid();
    test_zero_delay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
